fxp_add_pipe: RTL and testbench

FXP_ADD_PIPE -- requirements
Module: fxp_add_pipe

---
 rtl/fxp_add_pipe.sv | 106 ++++++++++
 tb/tb_fxp_add_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_add_pipe.sv
// Two-stage pipelined signed fixed-point adder/subtractor with valid/ready handshakes,
// optional saturation and a saturating overflow event counter.
module fxp_add_pipe #(
  parameter int DATA_W = 19,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              op_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic [CNT_W-1:0]  ovf_cnt,
  input  logic              cnt_clr
);

  localparam int SW = DATA_W + 1;
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic              s1_v_q, s1_v_d;
  logic [SW-1:0]     s1_sum_q, s1_sum_d;
  logic              s2_v_q, s2_v_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              out_xfer;
  logic [SW-1:0]     a_ext;
  logic [SW-1:0]     b_ext;
  logic              s1_ovf;

  // A stage may take new data when it is empty or its successor is advancing.
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    out_xfer = s2_v_q && out_ready && !rst;
    a_ext    = {data1[DATA_W-1], data1};
    b_ext    = {data2[DATA_W-1], data2};
    s1_ovf   = s1_sum_q[SW-1] ^ s1_sum_q[SW-2];

    s1_v_d   = s1_v_q;
    s1_sum_d = s1_sum_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sum_d = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);
      end
    end

    s2_v_d   = s2_v_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        ovf_d = s1_ovf;
        if ((SAT_EN != 0) && s1_ovf) begin
          result_d = s1_sum_q[SW-1] ? MIN_VAL : MAX_VAL;
        end else begin
          result_d = s1_sum_q[DATA_W-1:0];
        end
      end
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_sum_q <= '0;
      s2_v_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_sum_q <= s1_sum_d;
      s2_v_q   <= s2_v_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = rst || s1_adv;
  assign out_valid = s2_v_q && !rst;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_fxp_add_pipe.sv
// Randomized and directed bench for fxp_add_pipe: saturating, wrapping and 2-bit-counter
// instances share one input stream and are checked against a queue-based reference model.
module tb_fxp_add_pipe;

  localparam int DW = 19;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          op_sub;
  logic          out_ready;
  logic          cnt_clr;

  logic          s_in_ready, s_out_valid, s_ovf;
  logic [DW-1:0] s_result;
  logic [15:0]   s_ovf_cnt;
  logic          w_in_ready, w_out_valid, w_ovf;
  logic [DW-1:0] w_result;
  logic [15:0]   w_ovf_cnt;
  logic          c_in_ready, c_out_valid, c_ovf;
  logic [DW-1:0] c_result;
  logic [1:0]    c_ovf_cnt;

  fxp_add_pipe #(.DATA_W(DW), .SAT_EN(1), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .data1(data1), .data2(data2), .op_sub(op_sub), .out_valid(s_out_valid),
    .out_ready(out_ready), .result(s_result), .ovf(s_ovf), .ovf_cnt(s_ovf_cnt),
    .cnt_clr(cnt_clr));

  fxp_add_pipe #(.DATA_W(DW), .SAT_EN(0), .CNT_W(16)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .data1(data1), .data2(data2), .op_sub(op_sub), .out_valid(w_out_valid),
    .out_ready(out_ready), .result(w_result), .ovf(w_ovf), .ovf_cnt(w_ovf_cnt),
    .cnt_clr(cnt_clr));

  fxp_add_pipe #(.DATA_W(DW), .SAT_EN(1), .CNT_W(2)) dut_cnt2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .data1(data1), .data2(data2), .op_sub(op_sub), .out_valid(c_out_valid),
    .out_ready(out_ready), .result(c_result), .ovf(c_ovf), .ovf_cnt(c_ovf_cnt),
    .cnt_clr(cnt_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          op;
    int            acc;
  } entry_t;

  entry_t q[$];
  int     edgeNum;
  int     lastDepart;
  int     cnt16;
  int     cnt2;
  bit     modelValid;
  bit     lastXferIn;
  int     outSeen;
  bit     sawStall;
  int     compared;
  int     mismatched;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return v[DW-1] ? (longint'(v) - 64'sd524288) : longint'(v);
  endfunction

  // Exact integer arithmetic, then range check against the 19-bit signed limits.
  function automatic void refCalc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic op, input bit sat,
                                  output logic [DW-1:0] r, output logic o);
    longint sum;
    sum = op ? (sx(a) - sx(b)) : (sx(a) + sx(b));
    o = (sum > 262143) || (sum < -262144);
    if (sat && o) r = (sum > 0) ? 19'h3FFFF : 19'h40000;
    else          r = DW'(sum);
  endfunction

  task automatic applyStimulus(input bit r, input bit iv, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input bit op, input bit ordy,
                               input bit clr);
    bit            expOv, expIr, xin, xout, headOvf;
    int            ready_at;
    logic [DW-1:0] er;
    logic          eo;
    rst = r; in_valid = iv; data1 = d1; data2 = d2; op_sub = op;
    out_ready = ordy; cnt_clr = clr;
    #1;
    expOv = 1'b0;
    if (!r && q.size() > 0) begin
      ready_at = (q[0].acc + 1 > lastDepart) ? q[0].acc + 1 : lastDepart;
      expOv = (edgeNum >= ready_at);
    end
    expIr = r || (q.size() < 2) || ordy;
    checkOutput("s_out_valid", 32'(s_out_valid), 32'(expOv));
    checkOutput("w_out_valid", 32'(w_out_valid), 32'(expOv));
    checkOutput("c_out_valid", 32'(c_out_valid), 32'(expOv));
    checkOutput("s_in_ready", 32'(s_in_ready), 32'(expIr));
    checkOutput("w_in_ready", 32'(w_in_ready), 32'(expIr));
    headOvf = 1'b0;
    if (modelValid) begin
      checkOutput("s_ovf_cnt", 32'(s_ovf_cnt), 32'(cnt16));
      checkOutput("w_ovf_cnt", 32'(w_ovf_cnt), 32'(cnt16));
      checkOutput("c_ovf_cnt", 32'(c_ovf_cnt), 32'(cnt2));
      if (expOv) begin
        refCalc(q[0].a, q[0].b, q[0].op, 1'b1, er, eo);
        headOvf = eo;
        checkOutput("s_result", 32'(s_result), 32'(er));
        checkOutput("s_ovf", 32'(s_ovf), 32'(eo));
        checkOutput("c_result", 32'(c_result), 32'(er));
        refCalc(q[0].a, q[0].b, q[0].op, 1'b0, er, eo);
        checkOutput("w_result", 32'(w_result), 32'(er));
        checkOutput("w_ovf", 32'(w_ovf), 32'(eo));
      end
    end
    if (s_out_valid && ordy && !r) outSeen++;
    if (!s_in_ready) sawStall = 1'b1;
    xin  = iv && expIr && !r;
    xout = expOv && ordy;
    @(posedge clk);
    edgeNum++;
    if (r) begin
      q.delete();
      lastDepart = 0;
      cnt16 = 0;
      cnt2 = 0;
      modelValid = 1'b1;
    end else begin
      if (clr) begin
        cnt16 = 0;
        cnt2 = 0;
      end else if (xout && headOvf) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
      if (xout) begin
        void'(q.pop_front());
        lastDepart = edgeNum;
      end
      if (xin) q.push_back('{a: d1, b: d2, op: op, acc: edgeNum});
    end
    lastXferIn = xin;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, DW'($urandom), DW'($urandom), 1'b0, ordy, 1'b0);
  endtask

  function automatic logic [DW-1:0] pickOperand();
    logic [DW-1:0] corner [5];
    corner[0] = 19'h3FFFF; corner[1] = 19'h40000; corner[2] = 19'h00000;
    corner[3] = 19'h00001; corner[4] = 19'h7FFFF;
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return DW'($urandom);
  endfunction

  logic [DW-1:0] streamA [8];
  logic [DW-1:0] streamB [8];
  int k;

  initial begin
    compared = 0; mismatched = 0; edgeNum = 0; lastDepart = 0;
    cnt16 = 0; cnt2 = 0; modelValid = 1'b0; outSeen = 0; sawStall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; data1 = '0; data2 = '0; op_sub = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b1, 19'h00005, 19'h00007, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 19'h00005, 19'h00007, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 32'(s_out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(s_in_ready), 32'd1);
    checkOutput("rst_ovf_cnt", 32'(s_ovf_cnt), 32'd0);
    checkOutput("rst_result", 32'(s_result), 32'd0);
    checkOutput("rst_ovf", 32'(s_ovf), 32'd0);

    applyStimulus(1'b0, 1'b1, 19'd100, 19'h7FFE2, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_valid_c1", 32'(s_out_valid), 32'd0);
    idleCycles(1, 1'b1);
    checkOutput("lat_valid_c2", 32'(s_out_valid), 32'd1);
    checkOutput("add_70", 32'(s_result), 32'd70);
    idleCycles(2, 1'b1);

    applyStimulus(1'b0, 1'b1, 19'h3FFFF, 19'h00001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 19'h40000, 19'h00001, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_max", 32'(s_result), 32'h3FFFF);
    checkOutput("wrap_min", 32'(w_result), 32'h40000);
    checkOutput("sat_ovf", 32'(s_ovf), 32'd1);
    idleCycles(3, 1'b1);
    checkOutput("ovf_cnt_2", 32'(s_ovf_cnt), 32'd2);

    applyStimulus(1'b0, 1'b1, 19'h00000, 19'h40000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 19'h40000, 19'h40000, 1'b1, 1'b1, 1'b0);
    checkOutput("zero_minus_min_wrap", 32'(w_result), 32'h40000);
    checkOutput("zero_minus_min_sat", 32'(s_result), 32'h3FFFF);
    idleCycles(1, 1'b1);
    checkOutput("min_minus_min", 32'(s_result), 32'd0);
    checkOutput("min_minus_min_ovf", 32'(s_ovf), 32'd0);
    idleCycles(2, 1'b1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 19'h3FFFF, 19'h00001, 1'b0, 1'b1, 1'b0);
    idleCycles(3, 1'b1);
    checkOutput("cnt2_sticks", 32'(c_ovf_cnt), 32'd3);
    applyStimulus(1'b0, 1'b1, 19'h3FFFF, 19'h00001, 1'b0, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    applyStimulus(1'b0, 1'b0, 19'h0, 19'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_beats_inc_c", 32'(c_ovf_cnt), 32'd0);
    checkOutput("clr_beats_inc_s", 32'(s_ovf_cnt), 32'd0);
    idleCycles(2, 1'b1);

    for (int i = 0; i < 8; i++) begin
      streamA[i] = pickOperand();
      streamB[i] = pickOperand();
    end
    outSeen = 0; sawStall = 1'b0; k = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, k < 8, streamA[k % 8], streamB[k % 8], c[0],
                    !(c >= 3 && c <= 6), 1'b0);
      if (lastXferIn) k++;
    end
    checkOutput("stream_out_count", 32'(outSeen), 32'd8);
    checkOutput("stream_stalled", 32'(sawStall), 32'd1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 19'h3FFFF, 19'h00002, 1'b0, 1'b0, 1'b0);
    checkOutput("full_in_ready", 32'(s_in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 19'h00001, 19'h00001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 19'd5, 19'd6, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rst_cnt", 32'(s_ovf_cnt), 32'd0);
    checkOutput("post_rst_valid_c1", 32'(s_out_valid), 32'd0);
    idleCycles(1, 1'b1);
    checkOutput("post_rst_valid_c2", 32'(s_out_valid), 32'd1);
    checkOutput("post_rst_result", 32'(s_result), 32'd11);
    idleCycles(2, 1'b1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(3) != 0, pickOperand(), pickOperand(),
                    1'($urandom), $urandom_range(9) < 7, $urandom_range(29) == 0);
    end
    idleCycles(4, 1'b1);
    checkOutput("drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
